// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: accepts one tagged operation,
// iterates 32 times (shift-add multiply or restoring divide), then holds
// the tagged result until the CDB grants a broadcast. A ROB flush aborts it.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int ROBEN_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ROBEN_W-1:0] in_ROBEN,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  input  logic               ROB_FLUSH_Flag,
  input  logic               cdb_grant,
  output logic               FU_Is_Free,
  output logic               out_valid,
  output logic [ROBEN_W-1:0] out_ROBEN,
  output logic [WIDTH-1:0]   out_result
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_e;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_e               state_q;
  logic [5:0]           cnt_q;
  logic [ROBEN_W-1:0]   tag_q;
  op_e                  op_q;
  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
  logic [WIDTH-1:0]     opnd_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic                 out_valid_q;
  logic [ROBEN_W-1:0]   out_roben_q;
  logic [WIDTH-1:0]     out_result_q;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     result_d;

  // One iteration of both datapaths, plus the final result selection.
  // The remainder always fits WIDTH bits (it is below the divisor, or is a
  // prefix of the dividend when dividing by zero), so only the trial value
  // carries the extra bit.
  always_comb begin
    sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    prod_d = {sum, prod_q[WIDTH-1:1]};
    trial  = {rem_q, quo_q[WIDTH-1]};
    if (trial >= {1'b0, opnd_q}) begin
      rem_d = WIDTH'(trial - {1'b0, opnd_q});
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL:   result_d = prod_d[WIDTH-1:0];
      OP_MULHU: result_d = prod_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  result_d = quo_d;
      default:  result_d = rem_d;
    endcase
  end

  // Control FSM with operand latching, iteration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      op_q         <= OP_MUL;
      opnd_q       <= '0;
      prod_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      out_valid_q  <= 1'b0;
      out_roben_q  <= '0;
      out_result_q <= '0;
    end else if (ROB_FLUSH_Flag) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_roben_q  <= '0;
      out_result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && (in_ROBEN != '0)) begin
            state_q <= S_BUSY;
            cnt_q   <= '0;
            tag_q   <= in_ROBEN;
            op_q    <= op_e'(in_op);
            opnd_q  <= in_op[1] ? in_B : in_A;
            prod_q  <= {{WIDTH{1'b0}}, in_B};
            rem_q   <= '0;
            quo_q   <= in_A;
          end
        end
        S_BUSY: begin
          prod_q <= prod_d;
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          if (cnt_q == CNT_LAST) begin
            state_q      <= S_DONE;
            out_valid_q  <= 1'b1;
            out_roben_q  <= tag_q;
            out_result_q <= result_d;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          if (cdb_grant) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_roben_q  <= '0;
            out_result_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FU_Is_Free = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_ROBEN  = out_roben_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a job-level model (pending job with a cycle
// countdown and a golden result from plain arithmetic) checked every cycle,
// plus hand-computed literal expectations in the directed sequence.
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [RW-1:0] in_ROBEN = '0;
  logic [1:0]    in_op = '0;
  logic [W-1:0]  in_A = '0;
  logic [W-1:0]  in_B = '0;
  logic          ROB_FLUSH_Flag = 1'b0;
  logic          cdb_grant = 1'b0;
  logic          FU_Is_Free;
  logic          out_valid;
  logic [RW-1:0] out_ROBEN;
  logic [W-1:0]  out_result;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mul_div_unit #(.WIDTH(W), .ROBEN_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ROBEN(in_ROBEN),
    .in_op(in_op), .in_A(in_A), .in_B(in_B), .ROB_FLUSH_Flag(ROB_FLUSH_Flag),
    .cdb_grant(cdb_grant), .FU_Is_Free(FU_Is_Free), .out_valid(out_valid),
    .out_ROBEN(out_ROBEN), .out_result(out_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] golden(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Job-level model: an accepted job becomes visible 32 edges later.
  bit          m_busy  = 1'b0;
  int          m_left  = 0;
  bit          m_valid = 1'b0;
  logic [RW-1:0] m_tag = '0, m_jtag = '0;
  logic [W-1:0]  m_res = '0, m_jres = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_left <= 0; m_valid <= 1'b0; m_tag <= '0; m_res <= '0;
    end else if (ROB_FLUSH_Flag) begin
      m_busy <= 1'b0; m_left <= 0; m_valid <= 1'b0; m_tag <= '0; m_res <= '0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1; m_tag <= m_jtag; m_res <= m_jres;
      end
    end else if (m_valid) begin
      if (cdb_grant) begin
        m_valid <= 1'b0; m_tag <= '0; m_res <= '0;
      end
    end else if (in_valid && in_ROBEN != '0) begin
      m_busy <= 1'b1; m_left <= 32;
      m_jtag <= in_ROBEN; m_jres <= golden(in_op, in_A, in_B);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("free",   64'(FU_Is_Free), 64'(!m_busy && !m_valid));
      check("valid",  64'(out_valid),  64'(m_valid));
      check("roben",  64'(out_ROBEN),  64'(m_tag));
      check("result", 64'(out_result), 64'(m_res));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] tag);
    in_valid = 1'b1; in_op = op; in_A = a; in_B = b; in_ROBEN = tag;
    step();
    in_valid = 1'b0;
    in_A = $urandom; in_B = $urandom; in_op = 2'($urandom); in_ROBEN = RW'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [RW-1:0] tag,
                        input logic [W-1:0] exp, input int hold);
    int n;
    accept(op, a, b, tag);
    wait_valid(n);
    check({name, "_latency"}, 64'(n), 64'd32);
    check({name, "_value"},   64'(out_result), 64'(exp));
    check({name, "_tag"},     64'(out_ROBEN), 64'(tag));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; in_ROBEN = RW'(i + 1);
      step();
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_value"}, 64'(out_result), 64'(exp));
    end
    in_valid = 1'b0;
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    check({name, "_cleared"}, 64'(out_valid), 64'd0);
    check({name, "_free"},    64'(FU_Is_Free), 64'd1);
  endtask

  initial begin
    int n;
    step();
    check("rst_free",   64'(FU_Is_Free), 64'd1);
    check("rst_valid",  64'(out_valid),  64'd0);
    check("rst_roben",  64'(out_ROBEN),  64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    step();

    run_op("mul_7x6",    2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 0);
    run_op("mulhu_ff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 0);
    run_op("mul_ff",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd6, 32'd14, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd7, 32'd2, 0);
    run_op("divu_by0",   2'b10, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 0);
    run_op("remu_by0",   2'b11, 32'd5, 32'd0, 5'd9, 32'd5, 0);
    run_op("backpress",  2'b00, 32'd1234, 32'd5678, 5'd10, 32'd7006652, 10);

    // Flush at the tenth BUSY cycle of a divide.
    accept(2'b10, 32'd1000, 32'd3, 5'd11);
    repeat (9) step();
    ROB_FLUSH_Flag = 1'b1;
    step();
    ROB_FLUSH_Flag = 1'b0;
    check("flush_busy_free", 64'(FU_Is_Free), 64'd1);
    repeat (35) step();
    check("flush_busy_novalid", 64'(out_valid), 64'd0);

    // Operation presented together with a flush is dropped.
    in_valid = 1'b1; in_ROBEN = 5'd12; ROB_FLUSH_Flag = 1'b1;
    step();
    in_valid = 1'b0; ROB_FLUSH_Flag = 1'b0;
    check("flush_drop_free", 64'(FU_Is_Free), 64'd1);

    // Flush wins over grant in the DONE cycle.
    accept(2'b00, 32'd2, 32'd2, 5'd13);
    wait_valid(n);
    check("flush_done_latency", 64'(n), 64'd32);
    check("flush_done_value", 64'(out_result), 64'd4);
    ROB_FLUSH_Flag = 1'b1; cdb_grant = 1'b1;
    step();
    ROB_FLUSH_Flag = 1'b0; cdb_grant = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_free",  64'(FU_Is_Free), 64'd1);

    // Asynchronous reset between edges while BUSY.
    accept(2'b00, 32'd9, 32'd9, 5'd14);
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    check("async_free",   64'(FU_Is_Free), 64'd1);
    check("async_valid",  64'(out_valid),  64'd0);
    check("async_result", 64'(out_result), 64'd0);
    step();
    rst = 1'b1;
    step();
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 5'd15, 32'd9, 0);

    // A zero tag is not an operation.
    in_valid = 1'b1; in_ROBEN = '0; in_op = 2'b00; in_A = 32'd3; in_B = 32'd3;
    step();
    in_valid = 1'b0;
    check("tag0_free", 64'(FU_Is_Free), 64'd1);
    repeat (33) step();
    check("tag0_novalid", 64'(out_valid), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
